// File: rtl/keypad_bcd_entry.sv
// Keypad front end: debounces the raw one-hot keypad code, emits one event per
// press and assembles up to NUM_DIGITS BCD digits with BACKSPACE/CLEAR/ENTER.
module keypad_bcd_entry #(
  parameter int NUM_DIGITS    = 3,
  parameter int STABLE_CYCLES = 4,
  parameter int SHIFT_MODE    = 0
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [15:0]                       onehot,
  output logic [4*NUM_DIGITS-1:0]           digits,
  output logic [$clog2(NUM_DIGITS+1)-1:0]   count,
  output logic                              full,
  output logic                              key_evt,
  output logic                              overflow,
  output logic                              valid,
  output logic                              locked
);
  localparam int DW = 4 * NUM_DIGITS;
  localparam int CW = $clog2(NUM_DIGITS + 1);
  localparam int SW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [SW-1:0] LAST = SW'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;

  state_t          state_q;
  logic [SW-1:0]   cnt_q;
  logic [15:0]     code_q;
  logic            need_rel_q;
  logic [DW-1:0]   digits_q, digits_d;
  logic [CW-1:0]   count_q, count_d;
  logic            locked_q, locked_d;
  logic            evt_q, evt_d;
  logic            ovf_q, ovf_d;
  logic            valid_q, valid_d;

  logic [15:0]     code;
  logic            accept;
  logic            is_digit, is_enter, is_bs, is_clr;
  logic [3:0]      dig;
  logic [DW+3:0]   ext_l, ext_r;

  // Anything that is not single-hot behaves exactly like no key at all.
  assign code = ((onehot & (onehot - 16'd1)) == 16'd0) ? onehot : 16'd0;

  always_comb begin
    is_digit = 1'b1;
    is_enter = 1'b0;
    is_bs    = 1'b0;
    is_clr   = 1'b0;
    dig      = 4'd0;
    case (code)
      16'h0008: dig = 4'd0;
      16'h0080: dig = 4'd1;
      16'h0040: dig = 4'd2;
      16'h0020: dig = 4'd3;
      16'h0800: dig = 4'd4;
      16'h0400: dig = 4'd5;
      16'h0200: dig = 4'd6;
      16'h8000: dig = 4'd7;
      16'h4000: dig = 4'd8;
      16'h2000: dig = 4'd9;
      16'h0001: begin is_digit = 1'b0; is_enter = 1'b1; end
      16'h0002: begin is_digit = 1'b0; is_bs    = 1'b1; end
      16'h0004: begin is_digit = 1'b0; is_clr   = 1'b1; end
      default:  is_digit = 1'b0;
    endcase
  end

  // A press is accepted on the edge that sees its STABLE_CYCLES-th identical sample.
  always_comb begin
    accept = 1'b0;
    if (state_q == PRESS_WAIT && code == code_q && cnt_q == LAST) accept = 1'b1;
    if (STABLE_CYCLES == 1 && state_q == IDLE && !need_rel_q && code != 16'd0) accept = 1'b1;
  end

  assign ext_l = {digits_q, dig};
  assign ext_r = {4'd0, digits_q};

  always_comb begin
    digits_d = digits_q;
    count_d  = count_q;
    locked_d = locked_q;
    evt_d    = 1'b0;
    ovf_d    = 1'b0;
    valid_d  = 1'b0;
    if (accept) begin
      if (is_digit) begin
        evt_d = 1'b1;
        if (locked_q) begin
          digits_d      = '0;
          digits_d[3:0] = dig;
          count_d       = CW'(1);
          locked_d      = 1'b0;
        end else if (count_q < CW'(NUM_DIGITS)) begin
          if (SHIFT_MODE == 1) digits_d = ext_l[DW-1:0];
          else begin
            for (int i = 0; i < NUM_DIGITS; i++)
              if (count_q == CW'(i)) digits_d[4*i +: 4] = dig;
          end
          count_d = count_q + CW'(1);
        end else begin
          ovf_d = 1'b1;
        end
      end else if (is_bs) begin
        evt_d = 1'b1;
        if (count_q != '0) begin
          if (SHIFT_MODE == 1) digits_d = ext_r[DW+3:4];
          else begin
            for (int i = 0; i < NUM_DIGITS; i++)
              if (count_q == CW'(i + 1)) digits_d[4*i +: 4] = 4'd0;
          end
          count_d  = count_q - CW'(1);
          locked_d = 1'b0;
        end
      end else if (is_clr) begin
        evt_d    = 1'b1;
        digits_d = '0;
        count_d  = '0;
        locked_d = 1'b0;
      end else if (is_enter) begin
        evt_d = 1'b1;
        if (count_q != '0 && !locked_q) begin
          valid_d  = 1'b1;
          locked_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      code_q     <= '0;
      // A key still down across reset must be released before it can count.
      need_rel_q <= (code != 16'd0);
      digits_q   <= '0;
      count_q    <= '0;
      locked_q   <= 1'b0;
      evt_q      <= 1'b0;
      ovf_q      <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      digits_q <= digits_d;
      count_q  <= count_d;
      locked_q <= locked_d;
      evt_q    <= evt_d;
      ovf_q    <= ovf_d;
      valid_q  <= valid_d;
      if (code == 16'd0) need_rel_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (code != 16'd0 && !need_rel_q) begin
            code_q <= code;
            if (STABLE_CYCLES == 1) state_q <= HELD;
            else begin
              state_q <= PRESS_WAIT;
              cnt_q   <= SW'(1);
            end
          end
        end
        PRESS_WAIT: begin
          if (code == 16'd0) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (code != code_q) begin
            code_q <= code;
            cnt_q  <= SW'(1);
          end else if (cnt_q == LAST) begin
            state_q <= HELD;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + SW'(1);
          end
        end
        HELD: begin
          if (code == 16'd0) begin
            if (STABLE_CYCLES == 1) state_q <= IDLE;
            else begin
              state_q <= RELEASE_WAIT;
              cnt_q   <= SW'(1);
            end
          end
        end
        RELEASE_WAIT: begin
          if (code != 16'd0) begin
            state_q <= HELD;
            cnt_q   <= '0;
          end else if (cnt_q == LAST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + SW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign digits   = digits_q;
  assign count    = count_q;
  assign full     = (count_q == CW'(NUM_DIGITS));
  assign key_evt  = evt_q;
  assign overflow = ovf_q;
  assign valid    = valid_q;
  assign locked   = locked_q;
endmodule

// File: doc/keypad_bcd_entry.md
Name: keypad_bcd_entry

Overview:
Parametrised successor to the keypad one-hot encoder. Takes the raw 16-bit one-hot keypad code, debounces it, and produces exactly one event per physical press. It assembles up to NUM_DIGITS BCD digits in one of two entry modes, and supports BACKSPACE, CLEAR and ENTER function keys. Sits between the keypad scanner and the display/arithmetic blocks.

Parameters:
NUM_DIGITS, 3, number of BCD digits held (1..8).
STABLE_CYCLES, 4, consecutive identical samples required to accept a press or release (>=1).
SHIFT_MODE, 0, 0 = positional (1st digit in [3:0], 2nd in [7:4], ...); 1 = calculator (new digit enters [3:0], older digits shift up one nibble).

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
onehot  input  16  keypad code, 0 = no key
digits  output  4*NUM_DIGITS  assembled BCD value
count  output  $clog2(NUM_DIGITS+1)  digits currently entered
full  output  1  count == NUM_DIGITS
key_evt  output  1  1-cycle pulse on each accepted press
overflow  output  1  1-cycle pulse: digit key pressed while full
valid  output  1  1-cycle pulse on accepted ENTER
locked  output  1  high after ENTER until next edit key

Behaviour:
- Reset (rst_n=0 at clk edge): digits=0, count=0, full=0, all pulses 0, locked=0, debouncer in IDLE, stability counter 0. Reset mid-press: the key must be released and pressed again to register.
- Key map: 0x0008→0, 0x0080→1, 0x0040→2, 0x0020→3, 0x0800→4, 0x0400→5, 0x0200→6, 0x8000→7, 0x4000→8, 0x2000→9; 0x0001=ENTER, 0x0002=BACKSPACE, 0x0004=CLEAR. 0x0010, 0x0100 and 0x1000 are ignored keys. Any input that is not zero and not single-hot is treated as 0.
- Debounce FSM: IDLE→(nonzero code)→PRESS_WAIT. PRESS_WAIT counts while the code equals the code latched on entry; a different code restarts the count with the new code; 0 returns to IDLE. On reaching STABLE_CYCLES identical samples → HELD, and the event is processed on that same edge. All outputs are registered, so key_evt is visible the cycle after the STABLE_CYCLES-th sample.
- HELD: no further events (no auto-repeat). Input 0 → RELEASE_WAIT. RELEASE_WAIT: STABLE_CYCLES consecutive 0 samples → IDLE; any nonzero sample → HELD.
- Ignored keys still pass through the debouncer but produce no key_evt.
- Digit event, count<NUM_DIGITS, locked=0:
  - SHIFT_MODE=0: nibble[count] ← digit.
  - SHIFT_MODE=1: digits ← {digits[4*NUM_DIGITS-5:0], digit}.
  - Then count+1.
- Digit event, locked=1: clear all digits first, then write the digit as the first digit; count=1; locked←0.
- Digit event, full and locked=0: digits unchanged; overflow pulses with key_evt.
- BACKSPACE, count>0:
  - SHIFT_MODE=0: nibble[count-1] ← 0.
  - SHIFT_MODE=1: shift right by one nibble, top nibble ← 0.
  - Then count-1; locked←0.
- BACKSPACE, count=0: no change; key_evt still pulses.
- CLEAR: digits=0, count=0, locked=0.
- ENTER, count>0 and locked=0: valid pulses; locked←1; digits and count held. ENTER with count=0 or locked=1: key_evt only.
- full is combinational from registered count.
- Every event that is not an ignored key pulses key_evt.

Test Plan:
- SHIFT_MODE=0, STABLE_CYCLES=4: press 0x0080 (1), 0x0040 (2), 0x0020 (3), each held 6 cycles with 6-cycle releases → digits=0x321, count=3, full=1, three key_evt pulses; key_evt goes high the 5th cycle after the press is applied.
- Bounce: onehot toggles 0x0080/0 every cycle for 10 cycles, then holds 0x0080 for 4 cycles → exactly one key_evt; digits[3:0]=1.
- SHIFT_MODE=1: enter 4,5,6 → 0x456; BACKSPACE → 0x045, count=2; a 4th digit with NUM_DIGITS=3 entered full → overflow pulse, value unchanged.
- ENTER after 7,8 → valid for 1 cycle, locked=1; then press 9 → digits=0x009 (positional mode), count=1, locked=0.
- CLEAR mid-entry → digits=0, count=0. Also: 0x0030 held 10 cycles and ignored key 0x0100 → no key_evt, no state change.
- Assert rst_n=0 for 1 cycle while a key is in HELD → all outputs 0; the held key produces no event until released and pressed again.
